aes_block_sequencer: RTL and testbench
======================================

// Module: aes_block_sequencer
// PURPOSE
// - Sequences one AES job of LEN 128-bit blocks through the datapath:
//   word stacker -> AES core -> result output port.
// - Clears and enables the stacker, and forwards each stacked block to the core.
// - Waits for the core result, then presents it downstream before fetching the next block.
// - Sits between the HWPE register file/FSM (start, len, done event) and the stacker/core pair.
// PARAMETERS
// - LEN_W  default 16  width of block-count fields; max job = 2**LEN_W-1 blocks
// PORTS
// - clk_i          in   1      clock
// - rst_i          in   1      async reset, active-high
// - start_i        in   1      job start pulse; sampled only in IDLE
// - abort_i        in   1      synchronous job abort; ignored in IDLE
// - len_i          in   LEN_W  job length in blocks; sampled with start_i
// - stk_clr_o      out  1      clear to word stacker
// - stk_en_o       out  1      enable to word stacker
// - stk_valid_i    in   1      stacker has a full 128-bit block
// - stk_ready_o    out  1      ready to stacker (block consumed)
// - core_valid_o   out  1      block offered to AES core
// - core_ready_i   in   1      core accepts block
// - core_done_i    in   1      core result valid (1-cycle pulse)
// - out_valid_o    out  1      result valid to downstream
// - out_ready_i    in   1      downstream accepts result
// - busy_o         out  1      job in progress (state != IDLE)
// - done_o         out  1      1-cycle end-of-job event
// - blk_cnt_o      out  LEN_W  blocks fully delivered in current/last job
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; len_r=0; blk_cnt_o=0.
// - FSM states: IDLE, CLR, FETCH, WAIT, OUT, DONE.
// - IDLE -> CLR on start_i=1.
//   - Latch len_r=len_i; clear blk_cnt_o=0.
// - CLR:
//   - stk_clr_o=1 for exactly one cycle.
//   - Next state: DONE if len_r==0, else FETCH.
// - stk_en_o=1 in FETCH, WAIT, OUT; 0 in IDLE, CLR, DONE.
// - FETCH:
//   - core_valid_o=stk_valid_i and stk_ready_o=core_ready_i, both combinational.
//   - Block transfer when stk_valid_i & core_ready_i; then -> WAIT.
// - WAIT:
//   - Hold until core_done_i=1, then -> OUT.
//   - core_done_i outside WAIT is ignored.
// - OUT:
//   - out_valid_o=1; held stable until out_ready_i=1.
//   - On handshake, blk_cnt_o increments by 1.
//   - Next state: DONE if the new count == len_r, else FETCH.
// - DONE:
//   - done_o=1 for one cycle, then -> IDLE.
//   - blk_cnt_o holds its value until the next start.
// - Pipeline depth is one block in flight; no overlap of FETCH with WAIT/OUT.
// - Minimum latency, all handshakes immediate:
//   - start at cycle 0 -> CLR at 1, FETCH at 2, WAIT at 3.
//   - core_done_i at cycle k -> OUT at k+1.
// - busy_o=1 in every state except IDLE, including DONE.
// - start_i while busy is ignored; len_i is not re-sampled.
// - abort_i in any non-IDLE state:
//   - That cycle: all handshake outputs forced 0, stk_clr_o=1.
//   - Next cycle: IDLE. No done_o; blk_cnt_o keeps its partial value.
// - abort_i and start_i together in IDLE: start wins (abort ignored in IDLE).
// - Counter arithmetic is unsigned LEN_W-bit. Wrap is impossible: the compare
//   against len_r stops the count before overflow.
// - Async reset mid-job returns to IDLE immediately with all outputs 0.
//   stk_clr_o is not asserted; the stacker has its own reset.
// CONFIGURATION
// - AES_SEQ_PERF_EN defined: adds port cyc_cnt_o out 32.
//   - Counts clock cycles while busy_o=1; cleared on an accepted start_i.
//   - Saturates at 32'hFFFF_FFFF; holds after DONE/abort.
// - Not defined: no cyc_cnt_o port, no counter logic; all other behaviour identical.
// TESTING
// - Reset: rst_i=1 mid-job (state WAIT) -> next edge all outputs 0, busy_o=0.
// - Nominal: len_i=3, stk/core/out always ready, core_done 4 cycles after accept
//   -> 3 out handshakes, blk_cnt_o=3, done_o pulses once, busy_o falls the cycle after.
// - Zero length: len_i=0 -> stk_clr_o at cycle 1, done_o at cycle 2,
//   no core_valid_o, blk_cnt_o=0.
// - Backpressure: len_i=2, out_ready_i low 5 cycles in OUT
//   -> out_valid_o held 6 cycles, no FETCH meanwhile; core_valid_o only when stk_valid_i.
// - Abort: len_i=4, abort_i in WAIT of block 2 -> stk_clr_o=1 that cycle,
//   IDLE next, no done_o, blk_cnt_o=1; start_i during job ignored.
// - PERF (AES_SEQ_PERF_EN): nominal len_i=1 job -> cyc_cnt_o equals busy_o-high
//   cycle count; new start clears it to 0.

Source files
------------

// File: rtl/aes_block_sequencer.sv
// Sequences one AES job of LEN 128-bit blocks: word stacker -> AES core -> output port.
// Optional build macro AES_SEQ_PERF_EN adds cyc_cnt_o, a saturating busy-cycle counter.
module aes_block_sequencer #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             stk_clr_o,
  output logic             stk_en_o,
  input  logic             stk_valid_i,
  output logic             stk_ready_o,
  output logic             core_valid_o,
  input  logic             core_ready_i,
  input  logic             core_done_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             done_o,
`ifdef AES_SEQ_PERF_EN
  output logic [LEN_W-1:0] blk_cnt_o,
  output logic [31:0]      cyc_cnt_o
`else
  output logic [LEN_W-1:0] blk_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FETCH,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] blk_cnt_q, blk_cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      blk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    blk_cnt_d    = blk_cnt_q;
    stk_clr_o    = 1'b0;
    stk_en_o     = 1'b0;
    stk_ready_o  = 1'b0;
    core_valid_o = 1'b0;
    out_valid_o  = 1'b0;
    done_o       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_CLR;
          len_d     = len_i;
          blk_cnt_d = '0;
        end
      end
      S_CLR: begin
        stk_clr_o = 1'b1;
        state_d   = (len_q == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        stk_en_o     = 1'b1;
        core_valid_o = stk_valid_i;
        stk_ready_o  = core_ready_i;
        if (stk_valid_i && core_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        stk_en_o = 1'b1;
        if (core_done_i) state_d = S_OUT;
      end
      S_OUT: begin
        stk_en_o    = 1'b1;
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          blk_cnt_d = blk_cnt_q + LEN_W'(1);
          state_d   = (blk_cnt_d == len_q) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort suppresses every handshake so no block or count update escapes this cycle.
    if (abort_i && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      len_d        = len_q;
      blk_cnt_d    = blk_cnt_q;
      stk_clr_o    = 1'b1;
      stk_ready_o  = 1'b0;
      core_valid_o = 1'b0;
      out_valid_o  = 1'b0;
      done_o       = 1'b0;
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign blk_cnt_o = blk_cnt_q;

`ifdef AES_SEQ_PERF_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if ((state_q == S_IDLE) && start_i) begin
      cyc_d = '0;
    end else if ((state_q != S_IDLE) && (cyc_q != 32'hFFFF_FFFF)) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end

  assign cyc_cnt_o = cyc_q;
`endif

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Randomized scoreboard bench for aes_block_sequencer: a driver models stacker, core and sink,
// a negedge monitor checks per-block and per-job expectations queued at job issue.
module tb_aes_block_sequencer;
  localparam int unsigned LEN_W = 16;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic [LEN_W-1:0] len_i = '0;
  logic             stk_valid_i = 1'b0;
  logic             core_ready_i = 1'b0;
  logic             core_done_i = 1'b0;
  logic             out_ready_i = 1'b0;
  logic             stk_clr_o, stk_en_o, stk_ready_o, core_valid_o;
  logic             out_valid_o, busy_o, done_o;
  logic [LEN_W-1:0] blk_cnt_o;
`ifdef AES_SEQ_PERF_EN
  logic [31:0]      cyc_cnt_o;
`endif

  aes_block_sequencer #(.LEN_W(LEN_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i), .len_i(len_i),
    .stk_clr_o(stk_clr_o), .stk_en_o(stk_en_o), .stk_valid_i(stk_valid_i),
    .stk_ready_o(stk_ready_o), .core_valid_o(core_valid_o), .core_ready_i(core_ready_i),
    .core_done_i(core_done_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .busy_o(busy_o), .done_o(done_o),
`ifdef AES_SEQ_PERF_EN
    .cyc_cnt_o(cyc_cnt_o),
`endif
    .blk_cnt_o(blk_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Expected blk_cnt_o at each out handshake, at each done_o, and just after an abort.
  int exp_out_q[$];
  int exp_done_q[$];
  int exp_abort_q[$];

  // Environment configuration and core model state.
  int p_stk = 100, p_core = 100, p_out = 100, hold = 0, lat_fix = 4;
  bit hold_chk = 0, timed = 0;
  int abort_blk = 0, job_acc = 0, cd = 0, ov_cnt = 0;
  bit acc_flag = 0;

  // Monitor state.
  bit clr_exp, abort_pend, done_pend, ovexp, ovhold, inflight, done_seen, first_acc;
  int start_cyc, cur_len, acc_cnt, busy_cnt, ov_run;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic miss(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event with no expectation queued (cycle %0d)", nm, cyc);
  endtask

  always @(negedge clk_i) begin
    if (rst_i) begin
      chk("rst_outs", 32'({stk_clr_o, stk_en_o, stk_ready_o, core_valid_o,
                           out_valid_o, busy_o, done_o}), 32'd0);
      chk("rst_blk", 32'(blk_cnt_o), 32'd0);
      {clr_exp, abort_pend, done_pend, ovexp, ovhold, inflight, done_seen, first_acc} = '0;
      acc_flag = 0;
      ov_run = 0;
    end else begin
      if (clr_exp) begin
        chk("clr_at_1", 32'(stk_clr_o), 32'd1);
`ifdef AES_SEQ_PERF_EN
        chk("perf_clear", cyc_cnt_o, 32'd0);
`endif
      end
      clr_exp = 0;
      if (done_pend || abort_pend) begin
        chk("busy_fall", 32'(busy_o), 32'd0);
`ifdef AES_SEQ_PERF_EN
        chk("perf_cnt", cyc_cnt_o, 32'(busy_cnt));
`endif
      end
      if (abort_pend) begin
        if (exp_abort_q.size() == 0) miss("abort_blk");
        else chk("abort_blk", 32'(blk_cnt_o), 32'(exp_abort_q.pop_front()));
      end
      done_pend  = 0;
      abort_pend = 0;

      if (start_i && !busy_o) begin
        clr_exp = 1;
        start_cyc = cyc;
        cur_len = int'(len_i);
        acc_cnt = 0;
        busy_cnt = 0;
        inflight = 0;
        done_seen = 0;
        first_acc = 1;
      end
      if (busy_o) busy_cnt++;

      if (abort_i && busy_o) begin
        chk("abort_outs", 32'({stk_clr_o, core_valid_o, stk_ready_o, out_valid_o, done_o}),
            32'h10);
        abort_pend = 1;
        inflight = 0;
        ovexp = 0;
        ovhold = 0;
      end else begin
        if (ovexp) chk("out_after_done", 32'(out_valid_o), 32'd1);
        if (ovhold) chk("out_hold", 32'(out_valid_o), 32'd1);
        ovexp = 0;
        ovhold = 0;
        if (core_valid_o || stk_ready_o)
          chk("fetch_comb", 32'({core_valid_o, stk_ready_o}), 32'({stk_valid_i, core_ready_i}));
        if (core_done_i && inflight && !done_seen) begin
          done_seen = 1;
          ovexp = 1;
        end
        if (core_valid_o && core_ready_i) begin
          chk("one_in_flight", 32'(inflight), 32'd0);
          if (first_acc && timed) chk("fetch_at_2", 32'(cyc - start_cyc), 32'd2);
          first_acc = 0;
          inflight = 1;
          done_seen = 0;
          acc_cnt++;
          acc_flag = 1;
        end
        ov_run = out_valid_o ? ov_run + 1 : 0;
        if (out_valid_o) begin
          chk("out_has_result", 32'({inflight, done_seen}), 32'd3);
          if (out_ready_i) begin
            if (exp_out_q.size() == 0) miss("out_blk");
            else chk("out_blk", 32'(blk_cnt_o), 32'(exp_out_q.pop_front()));
            if (hold_chk) chk("out_hold_len", 32'(ov_run), 32'(hold + 1));
            inflight = 0;
          end else begin
            ovhold = 1;
          end
        end
        if (done_o) begin
          chk("done_busy", 32'(busy_o), 32'd1);
          chk("done_acc", 32'(acc_cnt), 32'(cur_len));
          if (cur_len == 0) chk("done_at_2", 32'(cyc - start_cyc), 32'd2);
          if (exp_done_q.size() == 0) miss("done_blk");
          else chk("done_blk", 32'(blk_cnt_o), 32'(exp_done_q.pop_front()));
          done_pend = 1;
        end
      end
    end
  end

  // Per-cycle environment: stacker/core/sink behaviour plus stray start pulses while busy.
  task automatic drive_env();
    start_i = 1'b0;
    abort_i = 1'b0;
    core_done_i = 1'b0;
    if (acc_flag) begin
      acc_flag = 0;
      job_acc++;
      cd = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 5));
      if (abort_blk != 0 && job_acc == abort_blk) begin
        abort_i = 1'b1;
        cd = 0;
      end
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) core_done_i = 1'b1;
    end else if ($urandom_range(0, 7) == 0) begin
      core_done_i = 1'b1;
    end
    stk_valid_i  = (int'($urandom_range(0, 99)) < p_stk);
    core_ready_i = (int'($urandom_range(0, 99)) < p_core);
    ov_cnt = out_valid_o ? ov_cnt + 1 : 0;
    out_ready_i = (ov_cnt > hold) && (int'($urandom_range(0, 99)) < p_out);
    if (busy_o && $urandom_range(0, 15) == 0) begin
      start_i = 1'b1;
      len_i = LEN_W'($urandom);
    end
  endtask

  task automatic run_job(input int len, input int ab);
    bit fin;
    @(posedge clk_i); #1;
    drive_env();
    start_i = 1'b1;
    len_i = LEN_W'(len);
    abort_i = ($urandom_range(0, 3) == 0);
    job_acc = 0;
    abort_blk = ab;
    cd = 0;
    if (ab == 0) begin
      for (int i = 0; i < len; i++) exp_out_q.push_back(i);
      exp_done_q.push_back(len);
    end else begin
      for (int i = 0; i < ab - 1; i++) exp_out_q.push_back(i);
      exp_abort_q.push_back(ab - 1);
    end
    fin = 0;
    for (int i = 0; i < 3000 && !fin; i++) begin
      @(posedge clk_i); #1;
      drive_env();
      if (!busy_o) fin = 1;
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL job_timeout: busy still high, required idle (len %0d)", len);
    end
  endtask

  task automatic set_env(input int ps, input int pc, input int po, input int h,
                         input int lat, input bit hc, input bit tm);
    p_stk = ps; p_core = pc; p_out = po; hold = h; lat_fix = lat; hold_chk = hc; timed = tm;
  endtask

  initial begin
    bit hit;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    set_env(100, 100, 100, 0, 4, 0, 1);
    run_job(3, 0);
    run_job(0, 0);
    set_env(50, 100, 100, 5, 4, 1, 0);
    run_job(2, 0);
    set_env(100, 100, 100, 0, 4, 0, 1);
    run_job(4, 2);

    // Reset while the first block of a job is in WAIT.
    @(posedge clk_i); #1;
    drive_env();
    start_i = 1'b1;
    len_i = LEN_W'(3);
    job_acc = 0;
    abort_blk = 0;
    cd = 0;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk_i); #1;
      drive_env();
      if (job_acc == 1) begin
        rst_i = 1'b1;
        hit = 1;
      end
    end
    chk("reset_reached_wait", 32'(hit), 32'd1);
    repeat (2) @(posedge clk_i);
    #1;
    exp_out_q.delete();
    exp_done_q.delete();
    exp_abort_q.delete();
    cd = 0;
    acc_flag = 0;
    rst_i = 1'b0;

    for (int j = 0; j < 40; j++) begin
      int len, ab;
      len = int'($urandom_range(0, 5));
      ab = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, len)) : 0;
      set_env(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
              int'($urandom_range(30, 100)), 0, 0, 0, 0);
      run_job(len, ab);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk_i); #1;
        drive_env();
      end
    end

    repeat (3) @(posedge clk_i);
    #1;
    chk("queues_empty", 32'(exp_out_q.size() + exp_done_q.size() + exp_abort_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
